// File: rtl/instr_encoder.sv
// Assembles mnemonic/operand bundles into instr_width-bit words tagged with sequential program addresses.
// Latency 1 cycle; in_ready drops while an output word is held unaccepted, so accept+drain streams back-to-back.
module instr_encoder #(
    parameter int instr_width = 9,
    parameter int addr_width  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             mnem,
    input  logic [3:0]             ra,
    input  logic [3:0]             rb,
    input  logic [3:0]             rc,
    input  logic [5:0]             imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [instr_width-1:0] out_instr,
    output logic [addr_width-1:0]  out_addr,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   finished
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCEPT   = 2'd1,
        FINISHED = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [4:0] M_AND  = 5'd0;
    localparam logic [4:0] M_SLT  = 5'd1;
    localparam logic [4:0] M_OR   = 5'd2;
    localparam logic [4:0] M_BEQ  = 5'd3;
    localparam logic [4:0] M_LW   = 5'd4;
    localparam logic [4:0] M_SW   = 5'd5;
    localparam logic [4:0] M_INC  = 5'd6;
    localparam logic [4:0] M_NOT  = 5'd7;
    localparam logic [4:0] M_ADD  = 5'd8;
    localparam logic [4:0] M_ADDI = 5'd9;
    localparam logic [4:0] M_SUB  = 5'd10;
    localparam logic [4:0] M_TR   = 5'd11;
    localparam logic [4:0] M_JR   = 5'd12;
    localparam logic [4:0] M_SRL  = 5'd13;
    localparam logic [4:0] M_SRA  = 5'd14;
    localparam logic [4:0] M_SLL  = 5'd15;
    localparam logic [4:0] M_DONE = 5'd16;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_MNEM  = 2'd1;
    localparam logic [1:0] E_RANGE = 2'd2;
    localparam logic [1:0] E_OVFL  = 2'd3;

    state_t              state_q, state_d;
    logic [addr_width:0] cnt_q;

    logic [8:0] enc;
    logic       mnem_ok, opnd_ok, is_done;
    logic       ra_0_3, ra_4_7, ra_8_11, rb_0_3, rb_8_11, rc_8_11, imm_0_3;
    logic       tr_ra_ok, tr_rb_ok;
    logic [2:0] tr_a, tr_b;
    logic [1:0] bad_code;
    logic       accept, load, fail, drain;

    // Range windows that are aligned groups of four only need the upper two bits.
    assign ra_0_3   = (ra[3:2] == 2'b00);
    assign ra_4_7   = (ra[3:2] == 2'b01);
    assign ra_8_11  = (ra[3:2] == 2'b10);
    assign rb_0_3   = (rb[3:2] == 2'b00);
    assign rb_8_11  = (rb[3:2] == 2'b10);
    assign rc_8_11  = (rc[3:2] == 2'b10);
    assign imm_0_3  = (imm[5:2] == 4'b0000);
    assign tr_ra_ok = (ra >= 4'd1) && (ra <= 4'd8);
    assign tr_rb_ok = (rb >= 4'd5) && (rb <= 4'd12);
    // Modulo-8 subtraction is exact across the TR windows (8-1 -> 7, 12-5 -> 7).
    assign tr_a     = ra[2:0] - 3'd1;
    assign tr_b     = rb[2:0] - 3'd5;

    always_comb begin
        enc     = 9'd0;
        mnem_ok = 1'b1;
        opnd_ok = 1'b1;
        is_done = 1'b0;
        case (mnem)
            M_AND: begin
                enc     = {3'b000, ra[1:0], rb[1:0], 2'b00};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_SLT: begin
                enc     = {3'b000, ra[1:0], rb[1:0], 2'b01};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_OR: begin
                enc     = {3'b000, ra[1:0], rb[1:0], 2'b10};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_BEQ: begin
                enc     = {3'b000, ra[1:0], rb[1:0], 2'b11};
                opnd_ok = ra_0_3 & rb_8_11;
            end
            M_LW: begin
                enc     = {3'b001, ra[1:0], rb[1:0], 2'b00};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_SW: begin
                enc     = {3'b001, ra[1:0], rb[1:0], 2'b01};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_INC: enc = {3'b001, ra, 2'b10};
            M_NOT: enc = {3'b001, ra, 2'b11};
            M_ADD: begin
                enc     = {3'b010, ra[1:0], rb[1:0], rc[1:0]};
                opnd_ok = ra_4_7 & rb_0_3 & rc_8_11;
            end
            M_ADDI: begin
                enc     = {3'b011, ra[1:0], rb[1:0], imm[1:0]};
                opnd_ok = ra_8_11 & rb_0_3 & imm_0_3;
            end
            M_SUB: begin
                enc     = {3'b100, ra[1:0], rb[1:0], rc[1:0]};
                opnd_ok = ra_4_7 & rb_0_3 & rc_8_11;
            end
            M_TR: begin
                enc     = {3'b101, tr_a, tr_b};
                opnd_ok = tr_ra_ok & tr_rb_ok;
            end
            M_JR: enc = {3'b110, imm};
            M_SRL: begin
                enc     = {3'b111, ra[1:0], rb[1:0], 2'b00};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_SRA: begin
                enc     = {3'b111, ra[1:0], rb[1:0], 2'b01};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_SLL: begin
                enc     = {3'b111, ra[1:0], rb[1:0], 2'b10};
                opnd_ok = ra_4_7 & rb_0_3;
            end
            M_DONE: begin
                enc     = 9'b111000011;
                is_done = 1'b1;
            end
            default: mnem_ok = 1'b0;
        endcase
    end

    // Overflow outranks everything: once the program space is used up no bundle is legal.
    always_comb begin
        bad_code = E_NONE;
        if (cnt_q[addr_width])
            bad_code = E_OVFL;
        else if (!mnem_ok)
            bad_code = E_MNEM;
        else if (!opnd_ok)
            bad_code = E_RANGE;
    end

    assign in_ready = (state_q == ACCEPT) && (!out_valid || out_ready) && !start;
    assign accept   = in_valid && in_ready;
    assign load     = accept && (bad_code == E_NONE);
    assign fail     = accept && (bad_code != E_NONE);
    assign drain    = out_valid && out_ready;
    assign finished = (state_q == FINISHED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = ACCEPT;
            end
            ACCEPT: begin
                if (start)
                    state_d = ACCEPT;
                else if (fail)
                    state_d = FAULT;
                else if (load && is_done)
                    state_d = FINISHED;
            end
            FINISHED, FAULT: begin
                if (start)
                    state_d = ACCEPT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            err       <= 1'b0;
            err_code  <= E_NONE;
        end else if (start) begin
            cnt_q     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= E_NONE;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_instr <= instr_width'(enc);
                out_addr  <= cnt_q[addr_width-1:0];
                cnt_q     <= cnt_q + (addr_width+1)'(1);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            // Only the first error is recorded; it stays until start or reset.
            if (fail && !err) begin
                err      <= 1'b1;
                err_code <= bad_code;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a transaction-level reference model.
module tb_instr_encoder;

    localparam int AW     = 2;
    localparam int NSLOT  = 1 << AW;
    localparam int S_IDLE = 0;
    localparam int S_ACC  = 1;
    localparam int S_FIN  = 2;
    localparam int S_FLT  = 3;

    logic          clk = 1'b0;
    logic          reset_n, start, in_valid, in_ready, out_valid, out_ready, err, finished;
    logic [4:0]    mnem;
    logic [3:0]    ra, rb, rc;
    logic [5:0]    imm;
    logic [8:0]    out_instr;
    logic [AW-1:0] out_addr;
    logic [1:0]    err_code;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode, m_cnt, m_instr, m_addr, m_code;
    bit m_ov, m_err;

    instr_encoder #(.instr_width(9), .addr_width(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_code(err_code), .finished(finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sgn6(input logic [5:0] v);
        return v[5] ? int'(v) - 64 : int'(v);
    endfunction

    function automatic bit inr(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Encoding straight from the instruction table: opcode*64 + field values.
    function automatic void ref_enc(input int m, input int a, input int b, input int c, input int s,
                                    output bit ok, output int w);
        ok = 1'b0;
        w  = 0;
        case (m)
            0, 1, 2: begin ok = inr(a,4,7) && inr(b,0,3); w = 0*64 + (a-4)*16 + b*4 + m; end
            3:       begin ok = inr(a,0,3) && inr(b,8,11); w = 0*64 + a*16 + (b-8)*4 + 3; end
            4, 5:    begin ok = inr(a,4,7) && inr(b,0,3); w = 1*64 + (a-4)*16 + b*4 + (m-4); end
            6, 7:    begin ok = 1'b1; w = 1*64 + a*4 + (m-4); end
            8, 10:   begin
                ok = inr(a,4,7) && inr(b,0,3) && inr(c,8,11);
                w  = ((m == 8) ? 2 : 4)*64 + (a-4)*16 + b*4 + (c-8);
            end
            9:       begin ok = inr(a,8,11) && inr(b,0,3) && inr(s,0,3); w = 3*64 + (a-8)*16 + b*4 + s; end
            11:      begin ok = inr(a,1,8) && inr(b,5,12); w = 5*64 + (a-1)*8 + (b-5); end
            12:      begin ok = 1'b1; w = 6*64 + ((s + 64) % 64); end
            13, 14, 15: begin ok = inr(a,4,7) && inr(b,0,3); w = 7*64 + (a-4)*16 + b*4 + (m-13); end
            16:      begin ok = 1'b1; w = 451; end
            default: begin ok = 1'b0; w = 0; end
        endcase
    endfunction

    task automatic check_outs();
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_instr", out_instr, m_instr);
            check("out_addr", out_addr, m_addr);
        end
        check("err", err, m_err);
        check("err_code", err_code, m_code);
        check("finished", finished, m_mode == S_FIN);
    endtask

    task automatic model_reset();
        m_mode = S_IDLE; m_cnt = 0; m_ov = 0; m_err = 0; m_code = 0; m_instr = 0; m_addr = 0;
    endtask

    // Called just after a falling edge: drive, check in_ready, advance model, check after next edge.
    task automatic cycle(input bit st, input bit iv, input int mn, input int a, input int b,
                         input int c, input logic [5:0] im, input bit ordy);
        bit rdy, ok, acc;
        int w, code;
        start = st; in_valid = iv; mnem = mn[4:0];
        ra = a[3:0]; rb = b[3:0]; rc = c[3:0]; imm = im; out_ready = ordy;
        #1;
        rdy = (m_mode == S_ACC) && (!m_ov || ordy) && !st;
        check("in_ready", in_ready, rdy);
        if (st) begin
            m_mode = S_ACC; m_cnt = 0; m_ov = 0; m_err = 0; m_code = 0;
        end else begin
            acc = iv && rdy;
            if (acc) begin
                ref_enc(mn, a, b, c, sgn6(im), ok, w);
                code = (m_cnt == NSLOT) ? 3 : (mn > 16) ? 1 : !ok ? 2 : 0;
                if (code != 0) begin
                    if (!m_err) m_code = code;
                    m_err  = 1;
                    m_mode = S_FLT;
                    if (ordy) m_ov = 0;
                end else begin
                    m_ov = 1; m_instr = w; m_addr = m_cnt; m_cnt++;
                    if (mn == 16) m_mode = S_FIN;
                end
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_instr"}, out_instr, 0);
        check({tag, ".out_addr"}, out_addr, 0);
        check({tag, ".in_ready"}, in_ready, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".err_code"}, err_code, 0);
        check({tag, ".finished"}, finished, 0);
    endtask

    initial begin
        int mn, a, b, c, w;
        bit ok, st, iv;
        logic [5:0] im;

        reset_n = 1'b0; start = 0; in_valid = 0; mnem = 0; ra = 0; rb = 0; rc = 0; imm = 0; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // IDLE ignores bundles until start
        cycle(0, 1, 8, 5, 2, 9, 6'd0, 1);

        // ADD r5,r2,r9
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 1);
        cycle(0, 1, 8, 5, 2, 9, 6'd0, 1);
        check("add.instr", out_instr, 9'b010011001);
        check("add.addr", out_addr, 0);

        // JR -1, TR r8,r12 held off by 3 stalled cycles, then DONE
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 1);
        cycle(0, 1, 12, 0, 0, 0, 6'h3F, 0);
        check("jr.instr", out_instr, 9'b110111111);
        check("jr.addr", out_addr, 0);
        repeat (3) begin
            cycle(0, 1, 11, 8, 12, 0, 6'd0, 0);
            check("stall.instr", out_instr, 9'b110111111);
        end
        cycle(0, 1, 11, 8, 12, 0, 6'd0, 1);
        check("tr.instr", out_instr, 9'b101111111);
        check("tr.addr", out_addr, 1);
        cycle(0, 1, 16, 0, 0, 0, 6'd0, 1);
        check("done.instr", out_instr, 9'b111000011);
        check("done.addr", out_addr, 2);
        check("done.finished", finished, 1);
        cycle(0, 1, 6, 1, 0, 0, 6'd0, 1);

        // BEQ with rb out of window, then restart
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 1);
        cycle(0, 1, 3, 0, 7, 0, 6'd0, 1);
        check("beq.valid", out_valid, 0);
        check("beq.code", err_code, 2);
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 1);
        check("restart.err", err, 0);
        cycle(0, 1, 8, 4, 0, 8, 6'd0, 1);
        check("restart.addr", out_addr, 0);

        // illegal mnemonic
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 1);
        cycle(0, 1, 20, 5, 2, 9, 6'd0, 1);
        check("mnem20.code", err_code, 1);
        check("mnem20.valid", out_valid, 0);

        // fill all four slots, fifth overflows
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 6, 15, 0, 0, 6'd0, 1);
            if (i < NSLOT) begin
                check("inc.instr", out_instr, 9'b001111110);
                check("inc.addr", out_addr, i);
            end else begin
                check("ovfl.code", err_code, 3);
                check("ovfl.valid", out_valid, 0);
            end
        end

        // reset while a word is stalled
        cycle(1, 0, 0, 0, 0, 0, 6'd0, 0);
        cycle(0, 1, 8, 5, 2, 9, 6'd0, 0);
        check("pre_rst.valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #1 reset_n = 1'b1;
        cycle(0, 1, 8, 5, 2, 9, 6'd0, 1);
        check("post_rst.valid", out_valid, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            st = (m_mode != S_ACC) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            iv = ($urandom_range(0, 9) < 7);
            mn = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
            ok = 1'b0;
            a = 0; b = 0; c = 0; im = 6'd0;
            for (int k = 0; k < 60 && !ok; k++) begin
                a  = int'($urandom_range(0, 15));
                b  = int'($urandom_range(0, 15));
                c  = int'($urandom_range(0, 15));
                im = 6'($urandom_range(0, 63));
                ref_enc(mn, a, b, c, sgn6(im), ok, w);
                if ($urandom_range(0, 9) == 0) ok = 1'b1;
            end
            cycle(st, iv, mn, a, b, c, im, $urandom_range(0, 9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter instr_width, default 9, instruction word width.
REQ-002 SHALL have parameter addr_width, default 8, program address width (2^addr_width slots).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  pulse; clears address counter and error state, enters ACCEPT.
REQ-006 SHALL have port in_valid  input  1  mnemonic/operand bundle valid.
REQ-007 SHALL have port in_ready  output  1  bundle accepted when in_valid&in_ready at clk edge.
REQ-008 SHALL have port mnem  input  5  mnemonic code: AND=0 SLT=1 OR=2 BEQ=3 LW=4 SW=5 INC=6 NOT=7 ADD=8 ADDI=9 SUB=10 TR=11 JR=12 SRL=13 SRA=14 SLL=15 DONE=16; 17-31 illegal.
REQ-009 SHALL have ports ra, rb, rc  input  4 each  physical register numbers (0-15).
REQ-010 SHALL have port imm  input  6  signed immediate (ADDI uses unsigned 0-3).
REQ-011 SHALL have port out_valid  output  1  out_instr/out_addr valid.
REQ-012 SHALL have port out_ready  input  1  instruction-memory writer accepts word.
REQ-013 SHALL have port out_instr  output  instr_width  encoded instruction.
REQ-014 SHALL have port out_addr  output  addr_width  program address of out_instr.
REQ-015 SHALL have port err  output  1  sticky error flag; err_code  output  2  (1=illegal mnem, 2=operand range, 3=program overflow).
REQ-016 SHALL have port finished  output  1  high in FINISHED state.

Function
REQ-017 Encoding SHALL be {op[2:0], f[5:0]}; sub-op in bits[1:0] where listed.
REQ-018 AND/SLT/OR (op 000, sub 00/01/10), SW (001/01), SRL/SRA/SLL (111/00/01/10): ra 4-7 -> [5:4]=ra-4, rb 0-3 -> [3:2]=rb.
REQ-019 BEQ (000/11): ra 0-3 -> [5:4]=ra, rb 8-11 -> [3:2]=rb-8.
REQ-020 LW (001/00): ra (dest) 4-7 -> [5:4]=ra-4, rb (address) 0-3 -> [3:2]=rb.
REQ-021 INC (001/10), NOT (001/11): ra 0-15 -> [5:2]=ra.
REQ-022 ADD (010), SUB (100): ra 4-7 -> [5:4]=ra-4, rb 0-3 -> [3:2]=rb, rc 8-11 -> [1:0]=rc-8.
REQ-023 ADDI (011): ra 8-11 -> [5:4]=ra-8, rb 0-3 -> [3:2]=rb, imm 0-3 -> [1:0]=imm[1:0].
REQ-024 TR (101): ra 1-8 -> [5:3]=ra-1, rb 5-12 -> [2:0]=rb-5.
REQ-025 JR (110): imm -32..31 -> [5:0]=imm.
REQ-026 DONE SHALL encode 9'b111000011; unused operands ignored.
REQ-027 States SHALL be IDLE, ACCEPT, FINISHED, FAULT.
REQ-028 IDLE: in_ready=0; start -> ACCEPT.
REQ-029 ACCEPT: in_ready = !out_valid | out_ready; accepted legal bundle loads output register next edge (latency 1), out_addr = counter, counter+1.
REQ-030 out_valid SHALL hold with out_instr/out_addr stable until out_valid&out_ready; accept and drain in the same cycle SHALL give back-to-back words, no bubble.
REQ-031 Illegal mnem or any operand out of range: no word emitted, counter unchanged, err=1, err_code set, state -> FAULT.
REQ-032 Legal word accepted when counter = 2^addr_width-1: word emitted at that address; any later bundle -> err_code=3, FAULT (no wrap).
REQ-033 Accepted DONE: word emitted, state -> FINISHED; in_ready=0; finished=1.
REQ-034 FAULT/FINISHED: pending out_valid word SHALL still drain; start -> ACCEPT.
REQ-035 start in ACCEPT SHALL abort: counter=0, err cleared, pending out_valid dropped; start has priority over a same-cycle in_valid (bundle not accepted).
REQ-036 First error SHALL set err_code; it SHALL persist until start or reset.

Reset
REQ-037 reset_n low SHALL asynchronously force state=IDLE, counter=0, out_valid=0, out_instr=0, out_addr=0, in_ready=0, err=0, err_code=0, finished=0.
REQ-038 Reset mid-handshake SHALL drop any pending word; no out_valid after release until a new accepted bundle.

Verification
REQ-039 start; ADD ra=5 rb=2 rc=9, out_ready=1 -> next cycle out_valid=1, out_instr=9'b010011001, out_addr=0.
REQ-040 Stream JR imm=-1, TR ra=8 rb=12, DONE with out_ready=0 for 3 cycles -> in_ready=0 while held; words 110111111 @0, 101111111 @1, 111000011 @2; finished=1.
REQ-041 BEQ ra=0 rb=7 -> no out_valid, err=1, err_code=2, FAULT; start -> err=0, out_addr restarts 0.
REQ-042 mnem=20 -> err_code=1, counter unchanged.
REQ-043 addr_width=2, five INC ra=15 -> words 001111110 @0-3, fifth -> err_code=3.
REQ-044 reset_n low while out_valid=1, out_ready=0 -> all outputs 0 immediately; IDLE after release.
